// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic datapaths (serial adder
// and serial subtractor).
//   ser_state_t   : load/shift/done sequencing states
//   SER_W_DEFAULT : default operand width
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

  localparam int SER_W_DEFAULT = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle of the serial subtractor.
//   start_i   : start request (only honoured while the subtractor is idle)
//   a_i, b_i  : minuend / subtrahend, captured on the accepted start
//   busy_o    : operation in progress
//   done_o    : one-cycle pulse, diff_o/borrow_o valid from this cycle on
//   diff_o    : A - B mod 2^WIDTH, held until the next result
//   borrow_o  : final borrow (unsigned A < B), held like diff_o
//   ovf_o     : signed overflow, only when SERIAL_SUB_OVF_EN is defined
//   state_dbg : current sequencer state, for observation only
// Handshake: a start is accepted on a rising edge where start_i=1 and the
// subtractor is idle (busy_o=0); otherwise start_i is ignored, not queued.
// Modports: master = controller side, slave = subtractor side.
interface serial_subtractor_if
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SER_W_DEFAULT
);

  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] diff_o;
  logic             borrow_o;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_o;
`endif
  ser_state_t       state_dbg;

`ifdef SERIAL_SUB_OVF_EN
  modport master (
    output start_i, a_i, b_i,
    input  busy_o, done_o, diff_o, borrow_o, ovf_o, state_dbg
  );
  modport slave (
    input  start_i, a_i, b_i,
    output busy_o, done_o, diff_o, borrow_o, ovf_o, state_dbg
  );
`else
  modport master (
    output start_i, a_i, b_i,
    input  busy_o, done_o, diff_o, borrow_o, state_dbg
  );
  modport slave (
    input  start_i, a_i, b_i,
    output busy_o, done_o, diff_o, borrow_o, state_dbg
  );
`endif

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor used as the bit-slice of the serial subtractor.
//   a_i, b_i : minuend / subtrahend bits
//   bin_i    : borrow in
//   diff_o   : a - b - bin (bit)
//   bout_o   : borrow out
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  assign diff_o = a_i ^ b_i ^ bin_i;
  // Borrow when a<b outright, or when a==b and a borrow is already pending.
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B, LSB first, one bit per clock.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : serial_subtractor_if.slave (start/operands in, results out)
// Sequence: IDLE --start--> SHIFT (WIDTH cycles) --> DONE (1 cycle) --> IDLE.
// Results are registered on the DONE cycle, so done_o and the new
// diff_o/borrow_o appear together in the first IDLE cycle after DONE.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed overflow
// output ovf_o.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SER_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             done_q;
  logic             d_bit;
  logic             b_next;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_sr;
  logic             ovf_q;
`endif

  full_subtractor u_slice (
    .a_i    (a_sr[0]),
    .b_i    (b_sr[0]),
    .bin_i  (br),
    .diff_o (d_bit),
    .bout_o (b_next)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      diff_sr  <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_sr   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            a_sr    <= bus.a_i;
            b_sr    <= bus.b_i;
            diff_sr <= '0;
            br      <= 1'b0;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          // New result bit enters at the MSB; after WIDTH shifts the first
          // (LSB) result bit has reached bit 0.
          diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
          br      <= b_next;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit a_sr[0]/b_sr[0] are the operand sign bits.
            ovf_sr <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ d_bit);
`endif
            state  <= DONE;
          end
        end
        DONE: begin
          diff_q   <= diff_sr;
          borrow_q <= br;
          done_q   <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          ovf_q    <= ovf_sr;
`endif
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o    = (state != IDLE);
  assign bus.done_o    = done_q;
  assign bus.diff_o    = diff_q;
  assign bus.borrow_o  = borrow_q;
  assign bus.state_dbg = state;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf_o     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=8). Define SERIAL_SUB_OVF_EN to
// also exercise the overflow output.
module tb_serial_subtractor;

  localparam int W  = 8;
  localparam int QW = W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [QW-1:0] exp_q[$];   // {ovf, borrow, diff}
  logic [W-1:0]  held_diff   = '0;
  logic          held_borrow = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [QW-1:0] ref_model(input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    int ua, ub, sa, sb, sd;
    logic [W-1:0] dd;
    logic bo, ov;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    dd = W'(ua - ub);
    bo = (ua < ub);
    sd = sa - sb;
    ov = (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
    return {ov, bo, dd};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge; start is seen by the next rising edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start_i = 1'b1;
    bus.a_i     = a;
    bus.b_i     = b;
    exp_q.push_back(ref_model(a, b));
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.a_i     = W'($urandom);
    bus.b_i     = W'($urandom);
  endtask

  // Walks the operation one falling edge at a time (idx=1 is the first
  // SHIFT cycle). inject>0 pulses start_i with junk operands at that idx.
  // Returns at the falling edge of the done_o cycle.
  task automatic wait_done(input int inject);
    int idx = 1;
    int busy_n = 0;
    bit seen = 0;
    logic [QW-1:0] e;
    while (idx <= W + 6) begin
      if (idx == 2) begin
        check_eq("hold_diff", 32'(bus.diff_o), 32'(held_diff));
        check_eq("hold_borrow", 32'(bus.borrow_o), 32'(held_borrow));
      end
      if (bus.done_o) begin
        seen = 1;
        break;
      end
      if (bus.busy_o) busy_n++;
      if (inject != 0 && idx == inject) begin
        bus.start_i = 1'b1;
        bus.a_i     = W'($urandom);
        bus.b_i     = W'($urandom);
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
      idx++;
    end
    bus.start_i = 1'b0;
    check_eq("done_seen", 32'(seen), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (seen) begin
        check_eq("latency", 32'(idx), 32'(W + 2));
        check_eq("busy_cycles", 32'(busy_n), 32'(W + 1));
        check_eq("busy_at_done", 32'(bus.busy_o), 32'd0);
        check_eq("diff", 32'(bus.diff_o), 32'(e[W-1:0]));
        check_eq("borrow", 32'(bus.borrow_o), 32'(e[W]));
`ifdef SERIAL_SUB_OVF_EN
        check_eq("ovf", 32'(bus.ovf_o), 32'(e[W+1]));
`endif
      end
      held_diff   = e[W-1:0];
      held_borrow = e[W];
    end
  endtask

  // One cycle after a done: pulse over and no relaunch.
  task automatic check_quiet();
    @(negedge clk);
    check_eq("done_pulse_len", 32'(bus.done_o), 32'd0);
    check_eq("idle_after", 32'(bus.busy_o), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    bus.start_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(bus.busy_o), 32'd0);
    check_eq("rst_done", 32'(bus.done_o), 32'd0);
    check_eq("rst_diff", 32'(bus.diff_o), 32'd0);
    check_eq("rst_borrow", 32'(bus.borrow_o), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check_eq("rst_ovf", 32'(bus.ovf_o), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    start_op(8'd200, 8'd55);  wait_done(0); check_quiet();
    start_op(8'd5,   8'd10);  wait_done(0); check_quiet();
    start_op(8'd0,   8'd255); wait_done(0); check_quiet();
    start_op(8'd0,   8'd0);   wait_done(0);
    // back-to-back: start in the first idle cycle (the done cycle)
    start_op(8'd255, 8'd1);   wait_done(0); check_quiet();
    // start pulsed mid-SHIFT and during DONE: both ignored
    start_op(8'd100, 8'd37);  wait_done(3); check_quiet();
    start_op(8'd90,  8'd200); wait_done(W + 1); check_quiet();
    start_op(8'd255, 8'd255); wait_done(0); check_quiet();
`ifdef SERIAL_SUB_OVF_EN
    start_op(8'h80, 8'h01);   wait_done(0); check_quiet();
    start_op(8'h10, 8'h01);   wait_done(0); check_quiet();
    start_op(8'h7F, 8'hFF);   wait_done(0); check_quiet();
`endif

    for (int i = 0; i < 24; i++) begin
      start_op(W'($urandom), W'($urandom));
      wait_done(($urandom_range(0, 3) == 0) ? int'($urandom_range(2, W + 1)) : 0);
      if ($urandom_range(0, 1) == 1) check_quiet();
    end
    check_quiet();

    // reset in SHIFT cycle 4 after a nonzero held result
    start_op(8'd9, 8'd3);     wait_done(0); check_quiet();
    start_op(8'd77, 8'd200);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", 32'(bus.busy_o), 32'd0);
    check_eq("abort_diff", 32'(bus.diff_o), 32'd0);
    check_eq("abort_borrow", 32'(bus.borrow_o), 32'd0);
    check_eq("abort_done", 32'(bus.done_o), 32'd0);
    dones = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (bus.done_o) dones++;
    end
    check_eq("abort_no_done", 32'(dones), 32'd0);
    exp_q.delete();
    held_diff   = '0;
    held_borrow = 1'b0;

    // recovery after abort
    start_op(8'd31, 8'd200);  wait_done(0); check_quiet();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
